// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM and working-state types, and the FIPS 180-4 logical functions
// shared by the compression core and its round sub-module.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: consumes a..h plus K[t], W[t] and returns the next a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       work_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output work_t       work_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = work_i.h + big_sigma1(work_i.e) + ch(work_i.e, work_i.f, work_i.g) + k_i + w_i;
    assign t2 = big_sigma0(work_i.a) + maj(work_i.a, work_i.b, work_i.c);

    assign work_o = '{
        a: t1 + t2,
        b: work_i.a,
        c: work_i.b,
        d: work_i.c,
        e: work_i.d + t1,
        f: work_i.e,
        g: work_i.f,
        h: work_i.g
    };

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression engine: accepts padded 512-bit blocks, runs ROUNDS_PER_CYCLE rounds per
// clock with an inline message schedule, and chains blocks into a 256-bit digest.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int         R        = ROUNDS_PER_CYCLE;
    localparam logic [6:0] R7       = 7'(R);
    localparam logic [6:0] LAST_CNT = 7'(64 - R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("sha256_compress_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t       state_q, state_d;
    logic [31:0]  h_q [0:7];
    logic [31:0]  h_d [0:7];
    work_t        work_q, work_d;
    logic [31:0]  w_q [0:15];
    logic [31:0]  w_d [0:15];
    logic [6:0]   cnt_q, cnt_d;
    logic         last_q, last_d;
    logic [255:0] digest_q, digest_d;
    logic         busy_q;

    logic [31:0]  w_shift [0:15];
    logic [31:0]  h_fin [0:7];
    logic [255:0] work_flat;
    work_t        work_rnd;

    // Round chain: stage i consumes K[t+i] and W[t+i] (window slot i).
    for (genvar i = 0; i < R; i++) begin : g_round
        work_t      work_in;
        work_t      work_out;
        logic [5:0] k_idx;
        if (i == 0) begin : g_head
            assign work_in = work_q;
        end else begin : g_link
            assign work_in = g_round[i-1].work_out;
        end
        assign k_idx = cnt_q[5:0] + 6'(i);
        sha256_round u_round (
            .work_i (work_in),
            .k_i    (K[k_idx]),
            .w_i    (w_q[i]),
            .work_o (work_out)
        );
    end
    assign work_rnd = g_round[R-1].work_out;

    // Schedule: stage j produces W[t+16+j]; its t-2 and t-7 taps come from earlier stages once
    // they run past the end of the stored window.
    for (genvar j = 0; j < R; j++) begin : g_sched
        logic [31:0] w_m2;
        logic [31:0] w_m7;
        logic [31:0] w_new;
        if (j >= 2) begin : g_m2_chain
            assign w_m2 = g_sched[j-2].w_new;
        end else begin : g_m2_win
            assign w_m2 = w_q[14+j];
        end
        if (j >= 7) begin : g_m7_chain
            assign w_m7 = g_sched[j-7].w_new;
        end else begin : g_m7_win
            assign w_m7 = w_q[9+j];
        end
        assign w_new = small_sigma1(w_m2) + w_m7 + small_sigma0(w_q[1+j]) + w_q[j];
    end

    for (genvar i = 0; i < 16; i++) begin : g_shift
        if (i < 16 - R) begin : g_keep
            assign w_shift[i] = w_q[i+R];
        end else begin : g_fresh
            assign w_shift[i] = g_sched[i-(16-R)].w_new;
        end
    end

    assign work_flat = work_q;
    for (genvar i = 0; i < 8; i++) begin : g_fin
        assign h_fin[i] = h_q[i] + work_flat[255-32*i -: 32];
    end

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        work_d   = work_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        digest_d = digest_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 8; i++) h_d[i] = blk_first ? IV[i] : h_q[i];
                    work_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
                    for (int i = 0; i < 16; i++) w_d[i] = blk_data[511-32*i -: 32];
                    cnt_d   = '0;
                    last_d  = blk_last;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = work_rnd;
                w_d    = w_shift;
                cnt_d  = cnt_q + R7;
                if (cnt_q == LAST_CNT) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                h_d = h_fin;
                if (last_q) begin
                    for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_fin[i];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (digest_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            h_q      <= IV;
            work_q   <= '0;
            // NOTE: the W window is reset explicitly; unlike a RAM it is plain flops that the
            // first round could otherwise see as X until a block is loaded.
            w_q      <= '{default: '0};
            cnt_q    <= '0;
            last_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != ST_IDLE);
            h_q      <= h_d;
            work_q   <= work_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            digest_q <= digest_d;
        end
    end

    assign blk_ready    = (state_q == ST_IDLE);
    assign digest_valid = (state_q == ST_DONE);
    assign digest       = digest_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Bench with four engines (R = 1, 2, 4, 8) sharing data inputs; a scoreboard queue holds expected
// digests and accept cycles, and a monitor checks value and latency whenever digest_valid rises.
module tb_sha256_compress_core;

    localparam int LANES = 4;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_448   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   blk_valid;
    logic [3:0]   blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic [3:0]   digest_valid;
    logic         digest_ready;
    logic [255:0] digest [LANES];
    logic [3:0]   busy;

    for (genvar k = 0; k < LANES; k++) begin : g_dut
        sha256_compress_core #(.ROUNDS_PER_CYCLE(1 << k)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .blk_valid    (blk_valid[k]),
            .blk_ready    (blk_ready[k]),
            .blk_data     (blk_data),
            .blk_first    (blk_first),
            .blk_last     (blk_last),
            .digest_valid (digest_valid[k]),
            .digest_ready (digest_ready),
            .digest       (digest[k]),
            .busy         (busy[k])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           lane;
        logic [255:0] dig;
        int           acc;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    function automatic int lat(input int lane);
        return (64 >> lane) + 2;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (the cycle after the accept edge).
    task automatic send(input int lane, input logic [511:0] data, input logic first,
                        input logic last, input bit expect_digest, input logic [255:0] dig,
                        input string name);
        int   budget;
        exp_t e;
        budget = 300;
        while (!blk_ready[lane] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, " ready_before_accept"}, 256'(blk_ready[lane]), 256'd1);
        blk_valid[lane] = 1'b1;
        blk_data        = data;
        blk_first       = first;
        blk_last        = last;
        if (expect_digest) begin
            e.lane = lane;
            e.dig  = dig;
            e.acc  = cyc + 1;
            e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        blk_valid = '0;
        check({name, " cycle1_busy"}, 256'(busy[lane]), 256'd1);
        check({name, " cycle1_ready"}, 256'(blk_ready[lane]), 256'd0);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 400;
        while ((exp_q.size() != 0 || blk_ready != 4'hf) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, " drain_pending"}, 256'(exp_q.size()), 256'd0);
        check({name, " drain_ready"}, 256'(blk_ready), 256'hf);
    endtask

    initial begin : monitor
        logic [3:0] dv_prev;
        exp_t       e;
        dv_prev = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < LANES; k++) begin
                if (rst && digest_valid[k] && !dv_prev[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_digest: lane %0d got %h, required no digest", k, digest[k]);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, " lane"}, 256'(k), 256'(e.lane));
                        check({e.name, " digest"}, digest[k], e.dig);
                        check({e.name, " latency"}, 256'(cyc - e.acc + 1), 256'(lat(e.lane)));
                    end
                end
            end
            dv_prev = digest_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        int budget;
        rst          = 1'b0;
        blk_valid    = '0;
        blk_data     = '0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        digest_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("reset_ready_l%0d", k), 256'(blk_ready[k]), 256'd1);
            check($sformatf("reset_busy_l%0d", k), 256'(busy[k]), 256'd0);
            check($sformatf("reset_valid_l%0d", k), 256'(digest_valid[k]), 256'd0);
            check($sformatf("reset_digest_l%0d", k), digest[k], 256'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC, "abc_r2");
        drain("abc_r2");

        for (int k = 0; k < LANES; k++) begin
            send(k, BLK_EMPTY, 1'b1, 1'b1, 1'b1, DIG_EMPTY, $sformatf("empty_r%0d", 1 << k));
            drain($sformatf("empty_r%0d", 1 << k));
        end

        // Two-block message on R=2: no digest after the first block, ready returns in cycle 34.
        send(1, BLK_2A, 1'b1, 1'b0, 1'b0, '0, "two_blk_a");
        repeat (32) @(negedge clk);
        check("two_blk_a final_ready", 256'(blk_ready[1]), 256'd0);
        check("two_blk_a final_busy", 256'(busy[1]), 256'd1);
        @(negedge clk);
        check("two_blk_a idle_ready", 256'(blk_ready[1]), 256'd1);
        check("two_blk_a idle_busy", 256'(busy[1]), 256'd0);
        check("two_blk_a no_digest", 256'(digest_valid[1]), 256'd0);
        send(1, BLK_2B, 1'b0, 1'b1, 1'b1, DIG_448, "two_blk_b");
        drain("two_blk");

        // Backpressure: digest held for 20 cycles while blk_valid pulses are ignored.
        digest_ready = 1'b0;
        send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC, "bp_abc");
        budget = 100;
        while (!digest_valid[1] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("bp wait_valid", 256'(digest_valid[1]), 256'd1);
        for (int n = 0; n < 20; n++) begin
            check($sformatf("bp_hold%0d digest", n), digest[1], DIG_ABC);
            check($sformatf("bp_hold%0d valid", n), 256'(digest_valid[1]), 256'd1);
            check($sformatf("bp_hold%0d ready", n), 256'(blk_ready[1]), 256'd0);
            blk_valid[1] = (n % 3 == 0);
            blk_data     = BLK_EMPTY;
            blk_first    = 1'b1;
            blk_last     = 1'b1;
            @(negedge clk);
        end
        blk_valid = '0;
        check("bp after_pulses digest", digest[1], DIG_ABC);
        check("bp after_pulses valid", 256'(digest_valid[1]), 256'd1);
        digest_ready = 1'b1;
        @(negedge clk);
        check("bp release valid", 256'(digest_valid[1]), 256'd0);
        check("bp release ready", 256'(blk_ready[1]), 256'd1);
        check("bp release busy", 256'(busy[1]), 256'd0);
        drain("bp");

        // Reset in ROUND cycle 10 aborts the block; H returns to the IV, so first=0 still hashes from it.
        send(1, BLK_ABC, 1'b1, 1'b1, 1'b0, '0, "rst_abc");
        repeat (9) @(negedge clk);
        check("rst_abc mid_round_busy", 256'(busy[1]), 256'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abc after_busy", 256'(busy[1]), 256'd0);
        check("rst_abc after_ready", 256'(blk_ready[1]), 256'd1);
        check("rst_abc after_valid", 256'(digest_valid[1]), 256'd0);
        check("rst_abc after_digest", digest[1], 256'd0);
        rst = 1'b1;
        @(negedge clk);
        send(1, BLK_EMPTY, 1'b0, 1'b1, 1'b1, DIG_EMPTY, "post_rst_empty");
        drain("post_rst_empty");

        // A first=1 block discards an unfinished chain.
        send(1, BLK_2A, 1'b1, 1'b0, 1'b0, '0, "discard_a");
        drain("discard_a");
        send(1, BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC, "discard_abc");
        drain("discard_abc");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
